// File: rtl/stall_ctrl_if.sv
// Pipeline control bus between the core datapath and stall_ctrl.
// The master drives stall requests and branch resolution.
// The slave (stall_ctrl) returns the hold mask, the flush/redirect and the status flags.
interface stall_ctrl_if #(
   parameter int STALL_W = 6,
   parameter int CNT_W   = 2
);
   logic               rdy;
   logic               stallreq_if;
   logic               stallreq_id;
   logic               stallreq_ex;
   logic               stallreq_mem;
   logic               branch_taken_i;
   logic [31:0]        branch_target_i;
   logic [STALL_W-1:0] stall_sign;
   logic               flush_o;
   logic [31:0]        new_pc_o;
   logic [CNT_W-1:0]   cnt2_o;
   logic               stall_timeout_o;

   modport master (
      output rdy, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output branch_taken_i, branch_target_i,
      input  stall_sign, flush_o, new_pc_o, cnt2_o, stall_timeout_o
   );

   modport slave (
      input  rdy, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  branch_taken_i, branch_target_i,
      output stall_sign, flush_o, new_pc_o, cnt2_o, stall_timeout_o
   );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline control unit: combinational stall mask, registered branch flush with a
// redirect PC, a saturating id_ex bubble counter and a sticky stall watchdog.
// Handshake: there is no valid/ready pairing here; rdy=0 is a global freeze that
// holds every register and stalls every stage, and branch_taken_i is a one-cycle
// strobe that is taken only while EX is advancing and no flush is in progress.
module stall_ctrl #(
   parameter int             STALL_W   = 6,
   parameter int             CNT_W     = 2,
   parameter int             TMO_W     = 8,
   parameter logic [TMO_W-1:0] TMO_LIMIT = 8'd200
) (
   input  logic         clk,
   input  logic         rst,
   stall_ctrl_if.slave  bus,
   output logic [0:0]   o_dbg_state
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   logic [0:0]         r_state;
   logic [31:0]        r_new_pc;
   logic [CNT_W-1:0]   r_cnt2;
   logic [TMO_W-1:0]   r_wd;
   logic               r_timeout;
   logic [3:0]         w_depth;
   logic [STALL_W-1:0] w_stall_sign;
   logic               w_any_req;
   logic               w_id_bubble;
   logic               w_branch_take;

   // Number of stalled stages counted from the PC; a flush overrides IF/ID requests.
   always_comb begin
      w_depth = 4'd0;
      if (rst)                    w_depth = 4'd0;
      else if (!bus.rdy)          w_depth = 4'(STALL_W);
      else if (bus.stallreq_mem)  w_depth = 4'd5;
      else if (bus.stallreq_ex)   w_depth = 4'd4;
      else if (r_state == S_FLUSH) w_depth = 4'd0;
      else if (bus.stallreq_id)   w_depth = 4'd3;
      else if (bus.stallreq_if)   w_depth = 4'd2;
      else                        w_depth = 4'd0;
   end

   assign w_stall_sign  = ~({STALL_W{1'b1}} << w_depth);
   assign w_any_req     = bus.stallreq_if | bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;
   assign w_id_bubble   = w_stall_sign[2] & ~w_stall_sign[3];
   assign w_branch_take = bus.branch_taken_i & ~w_stall_sign[3] & (r_state == S_IDLE);

   // Flush FSM: capture a taken branch, hold the redirect until EX/MEM let it drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_new_pc <= 32'h0;
      end else if (bus.rdy) begin
         case (r_state)
            S_IDLE: begin
               if (w_branch_take) begin
                  r_state  <= S_FLUSH;
                  r_new_pc <= bus.branch_target_i;
               end
            end
            S_FLUSH: begin
               if (!bus.stallreq_mem && !bus.stallreq_ex) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Consecutive cycles in which id_ex loads a bubble, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt2 <= '0;
      end else if (bus.rdy) begin
         if (!w_id_bubble)       r_cnt2 <= '0;
         else if (r_cnt2 != '1)  r_cnt2 <= r_cnt2 + 1'b1;
      end
   end

   // Watchdog on request-driven stalls; the timeout flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd      <= '0;
         r_timeout <= 1'b0;
      end else if (bus.rdy) begin
         if (!w_any_req)              r_wd <= '0;
         else if (r_wd != TMO_LIMIT)  r_wd <= r_wd + 1'b1;
         if (r_wd == TMO_LIMIT)       r_timeout <= 1'b1;
      end
   end

   assign bus.stall_sign      = w_stall_sign;
   assign bus.flush_o         = (r_state == S_FLUSH);
   assign bus.new_pc_o        = r_new_pc;
   assign bus.cnt2_o          = r_cnt2;
   assign bus.stall_timeout_o = r_timeout;
   assign o_dbg_state         = r_state;

endmodule
